shift_add_mult_n: RTL

//  Parametrised sequential shift-and-add (peasant) multiplier, WIDTH x WIDTH -> 2*WIDTH.
//  Per-operation signed/unsigned mode, start/busy/done handshake, and early termination

---
 rtl/shift_add_mult_n_if.sv | 30 +++
 rtl/shift_add_mult_n.sv | 94 +++++++++
 2 files changed

// File: rtl/shift_add_mult_n_if.sv
// Handshake/data bundle for shift_add_mult_n.
//   start_i  : request a multiplication
//   signed_i : operands are two's complement
//   data0_i  : multiplier a
//   data1_i  : multiplicand b
//   busy_o   : iteration in progress
//   done_o   : one-cycle pulse, y_o just updated
//   y_o      : 2*WIDTH-bit product
// master drives the request side; slave is the multiplier.
interface shift_add_mult_n_if #(
   parameter int WIDTH = 16
);
   logic                 start_i;
   logic                 signed_i;
   logic [WIDTH-1:0]     data0_i;
   logic [WIDTH-1:0]     data1_i;
   logic                 busy_o;
   logic                 done_o;
   logic [2*WIDTH-1:0]   y_o;

   modport master (
      output start_i, signed_i, data0_i, data1_i,
      input  busy_o, done_o, y_o
   );

   modport slave (
      input  start_i, signed_i, data0_i, data1_i,
      output busy_o, done_o, y_o
   );
endinterface

// File: rtl/shift_add_mult_n.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Operands are converted to magnitudes on accept, the magnitude product is built
// one multiplier bit per cycle, and the sign is applied when the result is written.
// Iteration stops as soon as the remaining multiplier bits are all zero.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : shift_add_mult_n_if slave (start/signed/data0/data1 in, busy/done/y out)
module shift_add_mult_n #(
   parameter int WIDTH     = 16,
   parameter int SIGNED_EN = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   shift_add_mult_n_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;

   logic [WIDTH-1:0]     r_a;
   logic [2*WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0]   r_acc;
   logic                 r_neg;
   logic [2*WIDTH-1:0]   r_y;

   logic                 w_accept;
   logic                 w_sgn;
   logic [WIDTH-1:0]     w_abs0;
   logic [WIDTH-1:0]     w_abs1;

   // DONE behaves like IDLE for start_i, giving back-to-back operation.
   assign w_accept = (r_state != S_RUN) && bus.start_i;
   assign w_sgn    = bus.signed_i && (SIGNED_EN != 0);

   // Unsigned WIDTH-bit negate: |-2^(WIDTH-1)| = 2^(WIDTH-1) without overflow.
   assign w_abs0 = (w_sgn && bus.data0_i[WIDTH-1]) ? (~bus.data0_i + 1'b1) : bus.data0_i;
   assign w_abs1 = (w_sgn && bus.data1_i[WIDTH-1]) ? (~bus.data1_i + 1'b1) : bus.data1_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start_i) w_next = S_RUN;
         S_RUN:   if (r_a == '0)   w_next = S_DONE;
         S_DONE:  w_next = bus.start_i ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
         r_neg <= 1'b0;
         r_y   <= '0;
      end else if (w_accept) begin
         r_a   <= w_abs0;
         r_b   <= {{WIDTH{1'b0}}, w_abs1};
         r_acc <= '0;
         r_neg <= w_sgn && (bus.data0_i[WIDTH-1] ^ bus.data1_i[WIDTH-1]);
      end else if (r_state == S_RUN) begin
         if (r_a != '0) begin
            if (r_a[0]) begin
               r_acc <= r_acc + r_b;
            end
            r_a <= r_a >> 1;
            r_b <= r_b << 1;
         end else begin
            // A zero magnitude stays zero when negated, so neg_r needs no guard.
            r_y <= r_neg ? (~r_acc + 1'b1) : r_acc;
         end
      end
   end

   assign bus.busy_o = (r_state == S_RUN);
   assign bus.done_o = (r_state == S_DONE);
   assign bus.y_o    = r_y;

endmodule
